// File: rtl/mul_pkg.sv
// Shared definitions for the iterative HI/LO multiplier; the sign helpers are
// plain functions so the divider's signed variant can reuse them.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = 6;
  localparam int unsigned MUL_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } mul_state_e;

  // |x| as an unsigned magnitude; |-2^31| = 0x8000_0000 still fits.
  function automatic logic [MUL_WIDTH-1:0] mul_abs(input logic [MUL_WIDTH-1:0] x,
                                                   input logic is_signed);
    return (is_signed && x[MUL_WIDTH-1]) ? (~x + MUL_WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*MUL_WIDTH-1:0] mul_neg(input logic [2*MUL_WIDTH-1:0] x);
    return ~x + (2*MUL_WIDTH)'(1);
  endfunction

endpackage

// File: rtl/multu_if.sv
// Start/busy handshake and operand/result bus shared by the multiplier and the pipeline.
interface multu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, signed_op, a, b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, signed_op, a, b,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/multu.sv
// Sequential 32x32 shift-add multiplier for MULT/MULTU; 33-cycle start-to-done latency,
// result held in hi/lo until the next product.
module multu
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input logic   clock,
  input logic   reset_n,
  multu_if.slave bus
);

  mul_state_e state_q, state_d;

  logic [WIDTH-1:0]     mag_a_q;
  logic [WIDTH:0]       upper_q, upper_d;
  logic [WIDTH-1:0]     mult_q, mult_d;
  logic                 neg_q;
  logic [MUL_CNT_W-1:0] count_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (count_q == MUL_CNT_W'(MUL_ITER - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

  // One iteration: conditional add into the upper half, then shift {carry, upper, mult} right.
  always_comb begin
    sum     = upper_q + (mult_q[0] ? {1'b0, mag_a_q} : '0);
    upper_d = {1'b0, sum[WIDTH:1]};
    mult_d  = {sum[0], mult_q[WIDTH-1:1]};
    acc     = {upper_q[WIDTH-1:0], mult_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag_a_q <= '0;
      upper_q <= '0;
      mult_q  <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mag_a_q <= mul_abs(bus.a, bus.signed_op);
            mult_q  <= mul_abs(bus.b, bus.signed_op);
            neg_q   <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            upper_q <= '0;
            count_q <= '0;
          end
        end
        CALC: begin
          upper_q <= upper_d;
          mult_q  <= mult_d;
          count_q <= count_q + MUL_CNT_W'(1);
        end
        FINISH: begin
          {hi_q, lo_q} <= neg_q ? mul_neg(acc) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multu.sv
// Directed bench for multu: stimulus pushes expected products into a scoreboard,
// a negedge monitor pops and checks them whenever done pulses.
module tb_multu;

  logic clock;
  logic reset_n;
  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    logic [63:0] prod;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   busy_len;

  multu_if #(.WIDTH(32)) bus ();

  multu dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare on every done pulse, also the latency and the busy-run length.
  always @(negedge clock) begin
    exp_t e;
    if (bus.busy) begin
      busy_len++;
    end else begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("hi", 64'(bus.hi), 64'(e.prod[63:32]));
          check("lo", 64'(bus.lo), 64'(e.prod[31:0]));
          check("latency", 64'(cyc - e.cyc), 64'd33);
          check("busy_cycles", 64'(busy_len), 64'd33);
        end
      end
      busy_len = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge E0.
  task automatic start_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] prod);
    exp_t e;
    bus.start     = 1'b1;
    bus.signed_op = sop;
    bus.a         = a;
    bus.b         = b;
    @(posedge clock);
    #1;
    e.prod = prod;
    e.cyc  = cyc;
    exp_q.push_back(e);
    bus.start     = 1'b0;
    bus.signed_op = $urandom_range(0, 1);
    bus.a         = $urandom;
    bus.b         = $urandom;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done_cycle();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!bus.done && n < 60);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0, expected done=1");
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    busy_len      = 0;
    cyc           = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    start_op(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    wait_empty();
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_empty();
    start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_empty();
    start_op(1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000);
    wait_empty();
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_empty();
    start_op(1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0);
    wait_empty();

    // A start mid-operation with new operands must be ignored.
    start_op(1'b0, 32'd1000, 32'd1000, 64'd1000000);
    repeat (9) @(posedge clock);
    #1;
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.a         = 32'd5;
    bus.b         = 32'hFFFF_FFFD;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_empty();

    // Reset in the middle of 3x4 abandons it; hi/lo hold 1000000 beforehand.
    start_op(1'b0, 32'd3, 32'd4, 64'd12);
    repeat (11) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    start_op(1'b0, 32'd3, 32'd4, 64'd12);
    wait_empty();

    // Back-to-back: start issued in the done cycle of the previous product.
    start_op(1'b0, 32'd2, 32'd2, 64'd4);
    wait_done_cycle();
    start_op(1'b0, 32'd9, 32'd9, 64'd81);
    wait_empty();

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
